// File: rtl/coproc_defs.sv
// Shared matrix-coprocessor definitions: geometry, loader FSM encoding, size helper.
// Pure declarations, no logic.
package coproc_defs;

    localparam int MAT_DIM  = 5;
    localparam int ELEM_W   = 8;
    localparam int NUM_ELEM = MAT_DIM * MAT_DIM;
    localparam int FLAT_W   = NUM_ELEM * ELEM_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Out-of-range sizes (0 or above MAT_DIM) fall back to the full matrix.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        if (s == 3'd0 || s > 3'(MAT_DIM))
            return 3'(MAT_DIM);
        return s;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/column walker over an active size x size window of a MAT_DIM grid.
// Slot index is combinational from registered row/col; phase_done is a same-cycle pulse.
// No backpressure of its own: advances only on the caller's accept strobe.
module matrix_index_counter
    import coproc_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  logic       final_phase,
    input  logic [2:0] size,
    output logic [4:0] slot,
    output logic [5:0] count,
    output logic       phase_done
);

    logic [2:0] row;
    logic [2:0] col;
    logic       last_col;
    logic       last_row;

    assign last_col   = (col == size - 3'd1);
    assign last_row   = (row == size - 3'd1);
    assign phase_done = advance && last_col && last_row;
    assign slot       = 5'(row) * 5'(MAT_DIM) + 5'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= '0;
            col   <= '0;
            count <= '0;
        end else if (clear) begin
            row   <= '0;
            col   <= '0;
            count <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? 3'd0 : row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
            // The count parks on the final accept so it reads 2*size^2-1 while holding.
            if (!(phase_done && final_phase))
                count <= count + 6'd1;
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial element stream -> A/B flattened operand buses, held until the consumer takes them.
// op_valid rises one cycle after the final accept; in_ready is low outside LOAD_A/LOAD_B.
// Optional LOADER_SIZE_SEL_EN adds mat_size to load a smaller top-left sub-matrix.
module matrix_operand_loader
    import coproc_defs::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FLAT_W-1:0] A_flat,
    output logic [FLAT_W-1:0] B_flat,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy,
    output logic [5:0]        elem_idx
`ifdef LOADER_SIZE_SEL_EN
    ,
    input  logic [2:0]        mat_size
`endif
);

    state_t     state;
    logic       start_acc;
    logic       accept;
    logic [4:0] slot;
    logic       phase_done;
    logic [2:0] act_size;

    // A HOLD that is being released in the same cycle may take a new start directly.
    assign start_acc = start && ((state == IDLE) || (state == HOLD && op_ready));
    assign accept    = in_valid && in_ready;

`ifdef LOADER_SIZE_SEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            act_size <= 3'(MAT_DIM);
        else if (start_acc)
            act_size <= clamp_size(mat_size);
    end
`else
    assign act_size = 3'(MAT_DIM);
`endif

    matrix_index_counter u_idx (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (start_acc),
        .advance     (accept),
        .final_phase (state == LOAD_B),
        .size        (act_size),
        .slot        (slot),
        .count       (elem_idx),
        .phase_done  (phase_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            A_flat   <= '0;
            B_flat   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            op_valid <= 1'b0;
        end else if (start_acc) begin
            state    <= LOAD_A;
            A_flat   <= '0;
            B_flat   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            op_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        A_flat[slot*ELEM_W +: ELEM_W] <= in_data;
                        if (phase_done)
                            state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        B_flat[slot*ELEM_W +: ELEM_W] <= in_data;
                        if (phase_done) begin
                            state    <= HOLD;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            op_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (op_ready) begin
                        state    <= IDLE;
                        op_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
